// File: rtl/nco_capture_writer.sv
// ---------------------------------------------------------------------------
// nco_capture_writer
//
// Capture engine that loads a phase increment into the NCO, drops the
// settling samples, decimates the sample stream and writes a fixed-length
// burst of samples into the on-chip memory through its write-only s2 port.
//
// Parameters:
//   ADDR_W          memory word address width (matches s2 address)
//   SETTLE_SAMPLES  valid NCO samples discarded after each load (0..255)
//
// Ports:
//   clk_clk, reset_reset_n         clock, asynchronous active-low reset
//   cap_start / cap_abort          start pulse / immediate stop
//   cap_base, cap_len              window base word and sample count (0 = 2^ADDR_W)
//   cap_decim                      keep 1 of every cap_decim+1 valid samples
//   cap_phinc                      phase increment to load
//   nco_out_data / nco_out_valid   NCO sample {sin[35:18], cos[17:0]} and strobe
//   nco_in_data / nco_in_valid     phase increment and load strobe to the NCO
//   mem_*                          s2 master signals (no waitrequest)
//   cap_busy, cap_done, cap_count  status: running, sticky done, samples written
//
// Build option:
//   NCO_CAP_PACK16_EN  pack two 16-bit samples per 64-bit word
// ---------------------------------------------------------------------------
module nco_capture_writer #(
    parameter int ADDR_W         = 14,
    parameter int SETTLE_SAMPLES = 8
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              cap_start,
    input  logic              cap_abort,
    input  logic [ADDR_W-1:0] cap_base,
    input  logic [ADDR_W-1:0] cap_len,
    input  logic [7:0]        cap_decim,
    input  logic [31:0]       cap_phinc,
    input  logic [35:0]       nco_out_data,
    input  logic              nco_out_valid,
    output logic [31:0]       nco_in_data,
    output logic              nco_in_valid,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_clken,
    output logic              mem_write,
    output logic [63:0]       mem_writedata,
    output logic [7:0]        mem_byteenable,
    output logic              cap_busy,
    output logic              cap_done,
    output logic [ADDR_W:0]   cap_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_SAMPLES - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [7:0]        decim_q, decim_d;
    logic [31:0]       phinc_q, phinc_d;
    logic [7:0]        settle_q, settle_d;
    logic [7:0]        dcnt_q, dcnt_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              done_q, done_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [63:0]       data_q, data_d;
    logic [7:0]        be_q, be_d;

    logic              accept;
    logic [ADDR_W:0]   len_eff;
    logic [ADDR_W-1:0] word_idx;
    logic [17:0]       nco_sin, nco_cos;
    logic [63:0]       word_data;
    logic [7:0]        word_be;

    // A length of zero stands for the full 2^ADDR_W window.
    assign len_eff = {(len_q == '0), len_q};
    assign nco_sin = nco_out_data[35:18];
    assign nco_cos = nco_out_data[17:0];

`ifdef NCO_CAP_PACK16_EN
    logic [3:0] unused_lsbs;
    assign unused_lsbs = {nco_sin[1:0], nco_cos[1:0]};
    assign word_idx    = count_q[ADDR_W:1];
    assign word_data   = {2{nco_sin[17:2], nco_cos[17:2]}};
    assign word_be     = count_q[0] ? 8'hF0 : 8'h0F;
`else
    assign word_idx    = count_q[ADDR_W-1:0];
    assign word_data   = {{14{nco_sin[17]}}, nco_sin, {14{nco_cos[17]}}, nco_cos};
    assign word_be     = 8'hFF;
`endif

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            len_q    <= '0;
            decim_q  <= '0;
            phinc_q  <= '0;
            settle_q <= '0;
            dcnt_q   <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            be_q     <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            decim_q  <= decim_d;
            phinc_q  <= phinc_d;
            settle_q <= settle_d;
            dcnt_q   <= dcnt_d;
            count_q  <= count_d;
            done_q   <= done_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            be_q     <= be_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        decim_d  = decim_q;
        phinc_d  = phinc_q;
        settle_d = settle_q;
        dcnt_d   = dcnt_q;
        count_d  = count_q;
        done_d   = done_q;
        wr_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        be_d     = be_q;
        accept   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (cap_start) begin
                    base_d   = cap_base;
                    len_d    = cap_len;
                    decim_d  = cap_decim;
                    phinc_d  = cap_phinc;
                    done_d   = 1'b0;
                    count_d  = '0;
                    settle_d = '0;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                dcnt_d  = '0;
                state_d = (SETTLE_SAMPLES == 0) ? S_CAPTURE : S_SETTLE;
            end
            S_SETTLE: begin
                if (nco_out_valid) begin
                    if (settle_q == SETTLE_LAST) begin
                        dcnt_d  = '0;
                        state_d = S_CAPTURE;
                    end else begin
                        settle_d = settle_q + 8'd1;
                    end
                end
            end
            S_CAPTURE: begin
                // The final write is already on the bus when count reaches
                // len, so done lands one cycle after the last write.
                if (count_q == len_eff) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (nco_out_valid) begin
                    if (dcnt_q == '0) begin
                        accept = 1'b1;
                        dcnt_d = decim_q;
                    end else begin
                        dcnt_d = dcnt_q - 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            wr_d    = 1'b1;
            addr_d  = base_q + word_idx;
            data_d  = word_data;
            be_d    = word_be;
            count_d = count_q + 1'b1;
        end

        // Abort overrides a simultaneous start and any write about to issue.
        if (cap_abort) begin
            state_d = S_IDLE;
            wr_d    = 1'b0;
            done_d  = 1'b0;
            count_d = count_q;
        end
    end

    assign nco_in_valid   = (state_q == S_LOAD);
    assign nco_in_data    = nco_in_valid ? phinc_q : '0;
    assign cap_busy       = (state_q == S_LOAD) || (state_q == S_SETTLE) ||
                            (state_q == S_CAPTURE);
    assign cap_done       = done_q;
    assign cap_count      = count_q;
    assign mem_chipselect = wr_q;
    assign mem_clken      = wr_q;
    assign mem_write      = wr_q;
    assign mem_address    = addr_q;
    assign mem_writedata  = data_q;
    assign mem_byteenable = be_q;

endmodule

// File: tb/tb_nco_capture_writer.sv
// ---------------------------------------------------------------------------
// Testbench for nco_capture_writer. Expected writes (address, data, byte
// enables, cycle) are queued as samples are driven and popped when the DUT
// strobes the s2 port. Follows NCO_CAP_PACK16_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_nco_capture_writer;

    localparam int SETTLE = 8;

    typedef struct {
        logic [13:0] addr;
        logic [63:0] data;
        logic [7:0]  be;
        int          cyc;
    } wr_exp_t;

    logic        clk = 1'b0;
    bit          clk_run = 1'b1;
    logic        rst_n;
    logic        cap_start, cap_abort;
    logic [13:0] cap_base, cap_len;
    logic [7:0]  cap_decim;
    logic [31:0] cap_phinc;
    logic [35:0] nco_out_data;
    logic        nco_out_valid;
    logic [31:0] nco_in_data;
    logic        nco_in_valid;
    logic [13:0] mem_address;
    logic        mem_chipselect, mem_clken, mem_write;
    logic [63:0] mem_writedata;
    logic [7:0]  mem_byteenable;
    logic        cap_busy, cap_done;
    logic [14:0] cap_count;

    int      n_cmp = 0;
    int      n_bad = 0;
    int      cyc = 0;
    bit      mon_en = 1'b1;
    wr_exp_t exp_q[$];

    nco_capture_writer #(
        .ADDR_W(14),
        .SETTLE_SAMPLES(SETTLE)
    ) dut (
        .clk_clk        (clk),
        .reset_reset_n  (rst_n),
        .cap_start      (cap_start),
        .cap_abort      (cap_abort),
        .cap_base       (cap_base),
        .cap_len        (cap_len),
        .cap_decim      (cap_decim),
        .cap_phinc      (cap_phinc),
        .nco_out_data   (nco_out_data),
        .nco_out_valid  (nco_out_valid),
        .nco_in_data    (nco_in_data),
        .nco_in_valid   (nco_in_valid),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_clken      (mem_clken),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_byteenable (mem_byteenable),
        .cap_busy       (cap_busy),
        .cap_done       (cap_done),
        .cap_count      (cap_count)
    );

    always #5 if (clk_run) clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    function automatic logic [35:0] rand36();
        logic [35:0] r;
        r[31:0]  = $urandom();
        r[35:32] = 4'($urandom());
        return r;
    endfunction

    function automatic wr_exp_t mk_exp(logic [13:0] base, int unsigned k, logic [35:0] s, int c);
        wr_exp_t     e;
        logic [17:0] sn;
        logic [17:0] cs;
        sn = s[35:18];
        cs = s[17:0];
`ifdef NCO_CAP_PACK16_EN
        e.addr = base + 14'(k >> 1);
        e.data = {2{sn[17:2], cs[17:2]}};
        e.be   = (k % 2 == 1) ? 8'hF0 : 8'h0F;
`else
        e.addr = base + 14'(k);
        e.data = {{14{sn[17]}}, sn, {14{cs[17]}}, cs};
        e.be   = 8'hFF;
`endif
        e.cyc = c;
        return e;
    endfunction

    // Write monitor: every strobe must match the head of the expectation queue.
    always @(negedge clk) begin : monitor
        wr_exp_t e;
        if (mon_en && (mem_write || mem_chipselect || mem_clken)) begin
            chk("strobes", {mem_chipselect, mem_clken, mem_write}, 3'b111);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_cycle", cyc, e.cyc);
                chk("wr_addr", mem_address, e.addr);
                chk("wr_data", mem_writedata, e.data);
                chk("wr_be", mem_byteenable, e.be);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_nco"}, {nco_in_data, nco_in_valid}, 0);
        chk({tag, "_wdata"}, mem_writedata, 0);
        chk({tag, "_misc"}, {mem_address, mem_chipselect, mem_clken, mem_write,
                             mem_byteenable, cap_busy, cap_done, cap_count}, 0);
    endtask

    // One capture run. abort_after>0 aborts (with a simultaneous start) the
    // cycle after that many samples were accepted; stray issues a start
    // during CAPTURE that must be ignored.
    task automatic run_cap(input logic [13:0] base, input logic [13:0] len,
                           input logic [7:0] decim, input logic [31:0] phinc,
                           input bit rnd, input int abort_after, input bit stray);
        int unsigned len_eff, seen, acc, dcnt, budget;
        int          last_acc, stray_cyc;
        bit          abort_pend, finished;
        logic [35:0] s;
        len_eff    = (len == 0) ? 16384 : int'(len);
        seen       = 0;
        acc        = 0;
        dcnt       = 0;
        last_acc   = -10;
        stray_cyc  = -10;
        abort_pend = 1'b0;
        finished   = 1'b0;
        budget     = 64 + len_eff * (int'(decim) + 1) * 4;

        @(posedge clk); #1;
        cap_base      = base;
        cap_len       = len;
        cap_decim     = decim;
        cap_phinc     = phinc;
        cap_start     = 1'b1;
        nco_out_valid = 1'b0;
        @(posedge clk); #1;
        // LOAD cycle: a sample offered here is not part of the settle count.
        cap_start     = 1'b0;
        nco_out_valid = 1'b1;
        nco_out_data  = rand36();
        @(negedge clk);
        chk("load_valid", nco_in_valid, 1);
        chk("load_data", nco_in_data, phinc);
        chk("start_clr_done", cap_done, 0);
        chk("start_clr_count", cap_count, 0);
        chk("busy_load", cap_busy, 1);

        for (int unsigned i = 0; i < budget && !finished; i++) begin
            @(posedge clk); #1;
            cap_start     = 1'b0;
            cap_abort     = 1'b0;
            nco_out_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            s             = rand36();
            nco_out_data  = s;
            if (abort_pend) begin
                cap_abort = 1'b1;
                cap_start = 1'b1;
                cap_base  = ~base;
                @(posedge clk); #1;
                cap_abort = 1'b0;
                cap_start = 1'b0;
                @(negedge clk);
                chk("abort_busy", cap_busy, 0);
                chk("abort_done", cap_done, 0);
                chk("abort_count", cap_count, 64'(abort_after));
                chk("abort_no_load", nco_in_valid, 0);
                finished = 1'b1;
            end else begin
                if (nco_out_valid && acc < len_eff) begin
                    if (seen < SETTLE) begin
                        seen++;
                    end else if (dcnt == 0) begin
                        exp_q.push_back(mk_exp(base, acc, s, cyc + 1));
                        acc++;
                        last_acc = cyc;
                        dcnt     = decim;
                        if (acc == abort_after) abort_pend = 1'b1;
                        if (stray && acc == 1) begin
                            cap_start = 1'b1;
                            cap_base  = base + 14'd7;
                            cap_phinc = ~phinc;
                            stray_cyc = cyc + 1;
                        end
                    end else begin
                        dcnt--;
                    end
                end
                @(negedge clk);
                if (cyc == stray_cyc) chk("stray_no_load", nco_in_valid, 0);
                if (acc == len_eff && cyc == last_acc + 1) begin
                    chk("busy_last_wr", cap_busy, 1);
                    chk("done_not_yet", cap_done, 0);
                end
                if (acc == len_eff && cyc == last_acc + 2) begin
                    chk("done", cap_done, 1);
                    chk("busy_done", cap_busy, 0);
                    chk("count", cap_count, 64'(len_eff));
                    finished = 1'b1;
                end
            end
        end
        if (!finished) chk("timeout", 0, 1);
        @(posedge clk); #1;
        nco_out_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic reset_mid_capture();
        bit got;
        got    = 1'b0;
        mon_en = 1'b0;
        @(posedge clk); #1;
        cap_base  = 14'h0200;
        cap_len   = 14'd10;
        cap_decim = 8'd0;
        cap_phinc = 32'h0000_1234;
        cap_start = 1'b1;
        @(posedge clk); #1;
        cap_start     = 1'b0;
        nco_out_valid = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            nco_out_data = rand36();
            if (mem_write) got = 1'b1;
        end
        chk("rst_saw_write", got, 1);
        clk_run = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_mid");
        #20 rst_n = 1'b1;
        #2;
        nco_out_valid = 1'b0;
        exp_q.delete();
        mon_en  = 1'b1;
        clk_run = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        rst_n         = 1'b0;
        cap_start     = 1'b0;
        cap_abort     = 1'b0;
        cap_base      = '0;
        cap_len       = '0;
        cap_decim     = '0;
        cap_phinc     = '0;
        nco_out_data  = '0;
        nco_out_valid = 1'b0;
        #3 check_all_zero("rst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_cap(14'h0100, 14'd4, 8'd0, 32'h0123_4567, 1'b0, 0, 1'b0);  // basic
        run_cap(14'h0800, 14'd3, 8'd2, 32'h0BAD_F00D, 1'b0, 0, 1'b0);  // decimation
        run_cap(14'h3FFE, 14'd3, 8'd0, 32'h0000_0042, 1'b0, 0, 1'b0);  // wrap
        run_cap(14'h0040, 14'd3, 8'd0, 32'h1111_2222, 1'b0, 0, 1'b0);  // odd length
        run_cap(14'h1234, 14'd7, 8'd1, 32'hCAFE_0001, 1'b1, 0, 1'b1);  // gaps + stray start
        run_cap(14'h0300, 14'd8, 8'd0, 32'h5555_AAAA, 1'b0, 2, 1'b0);  // abort
        run_cap(14'h0010, 14'd0, 8'd0, 32'h8000_0000, 1'b0, 0, 1'b0);  // full window
        reset_mid_capture();
        run_cap(14'h0500, 14'd5, 8'd0, 32'h0F0F_0F0F, 1'b0, 0, 1'b0);  // after reset

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nco_capture_writer.md
# nco_capture_writer

Capture engine that drives the on-chip memory's second (s2) port as a write-only master, storing NCO output samples for later readout over PCIe. It sits beside the Qsys system in the top level. It programs the NCO phase increment, discards settling samples, and decimates the sample stream. It then writes a fixed-length burst of samples into a configurable memory window and reports completion.

## Interface
- `ADDR_W`, 14, memory word address width; matches s2 address.
- `SETTLE_SAMPLES`, 8, valid NCO samples discarded after each phase-increment load, range 0..255.

- `clk_clk` in 1: single clock, shared with NCO and s2 port.
- `reset_reset_n` in 1: asynchronous, active-low reset.
- `cap_start` in 1: one-cycle start pulse.
- `cap_abort` in 1: stop immediately and return to IDLE.
- `cap_base` in ADDR_W: first memory word address.
- `cap_len` in ADDR_W: sample count; 0 means 2^ADDR_W.
- `cap_decim` in 8: keep 1 of every (cap_decim+1) valid samples.
- `cap_phinc` in 32: phase increment to load into the NCO.
- `nco_out_data` in 36: NCO sample, {sin[35:18], cos[17:0]}, two's complement.
- `nco_out_valid` in 1: sample strobe.
- `nco_in_data` out 32: phase increment to the NCO.
- `nco_in_valid` out 1: phase-increment load strobe.
- `mem_address` out ADDR_W: s2 address.
- `mem_chipselect` out 1: s2 chipselect.
- `mem_clken` out 1: s2 clock enable.
- `mem_write` out 1: s2 write strobe.
- `mem_writedata` out 64: s2 write data.
- `mem_byteenable` out 8: s2 byte enables.
- `cap_busy` out 1: high in LOAD, SETTLE and CAPTURE.
- `cap_done` out 1: sticky completion flag; cleared by start, abort or reset.
- `cap_count` out ADDR_W+1: number of samples written in the current run.

## Operation
- Reset value of every output is 0. State resets to IDLE.
- **IDLE/DONE:**
  - `cap_start` latches base, len, decim and phinc, clears `cap_done` and `cap_count`, and goes to LOAD.
  - `cap_start` is ignored in every other state.
- **LOAD (1 cycle):** `nco_in_valid`=1 and `nco_in_data`=phinc. Next state is SETTLE, or CAPTURE when SETTLE_SAMPLES=0.
- **SETTLE:** counts valid samples and discards them. After the SETTLE_SAMPLES-th one, goes to CAPTURE with the decimation counter set to 0.
- **CAPTURE:**
  - On each valid sample, if the decimation counter is 0, the sample is accepted and the counter reloads with decim. Otherwise the counter decrements.
  - Each accepted sample k produces exactly one memory write, then k increments.
  - When k reaches len (0 means 2^ADDR_W), the state goes to DONE and `cap_done`=1.
- **Addresses:** base + word index, modulo 2^ADDR_W. The window wraps silently.
- **Default write format:**
  - One sample per word, word index = k.
  - `mem_writedata` = {sext32(sin), sext32(cos)}.
  - `mem_byteenable` = 8'hFF.
- **Write strobes:** `mem_chipselect`, `mem_clken` and `mem_write` pulse together for exactly one cycle per write and are 0 otherwise.
- **Abort:** takes priority over everything, including a simultaneous start or a write pending for the next cycle. The state returns to IDLE, the pending write is suppressed, `cap_done` stays 0, and `cap_count` holds its value.

## Timing
- Start accepted in cycle N → `nco_in_valid` high in cycle N+1, for one cycle.
- Accepted sample with `nco_out_valid` in cycle M → write strobes, address and data registered and valid in cycle M+1.
- `cap_count` increments in the same cycle as its write.
- Last write in cycle W → `cap_done`=1 and `cap_busy`=0 from cycle W+1.
- Back-to-back valid samples with decim=0 → one write per cycle with no bubbles. The s2 port has no waitrequest, so there is no backpressure.
- Abort sampled in cycle A → no write in cycle A+1 or later, and `cap_busy`=0 from A+1.
- Reset asserted mid-write → all outputs go to 0 immediately.

## Configuration
- **`NCO_CAP_PACK16_EN` defined:** two samples are packed per 64-bit word.
  - Sample k goes to word index k>>1.
  - Data is {sin[17:2], cos[17:2]} replicated in both 32-bit halves.
  - `mem_byteenable` = 8'h0F for even k and 8'hF0 for odd k.
  - `cap_len` still counts samples, so an odd len leaves the upper half of the last word untouched.
- **Not defined:** one sign-extended sample per word, as described above.

## Test plan
- **Basic capture:** base=0x0100, len=4, decim=0, SETTLE_SAMPLES=8, NCO valid every cycle → LOAD pulse with phinc, 8 samples dropped, then writes to 0x0100..0x0103 on consecutive cycles. Expect `cap_done`=1 one cycle after the last write and `cap_count`=4.
- **Decimation:** decim=2, len=3, valid every cycle → writes contain accepted samples 0, 3 and 6 of the post-settle stream, spaced 3 cycles apart.
- **Wrap and zero length:** base=0x3FFE, len=3 → addresses 0x3FFE, 0x3FFF, 0x0000. Separately, len=0 → 16384 writes before done.
- **Abort:** abort one cycle after the 2nd accepted sample, with start asserted simultaneously → no 3rd write, IDLE next cycle, `cap_done`=0, `cap_count`=2. Start during CAPTURE is ignored.
- **Pack mode (`NCO_CAP_PACK16_EN`):** len=3 → three writes to base, base and base+1 with byteenables 0F, F0, 0F.
- **Async reset mid-CAPTURE:** every output goes to 0 while the clock is stopped. After release, a new start runs normally.
